// File: rtl/wb_sdram_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter in front of
// the SDRAM bridge: state encoding, master indices and the request record.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic M_IBUS = 1'b0;
  localparam logic M_DBUS = 1'b1;

  localparam int TIMEOUT_W_DEFAULT = 10;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

  // Round-robin choice: on a tie the master that did not win last time goes.
  function automatic logic rr_pick(input logic req_ibus, input logic req_dbus,
                                   input logic last_gnt);
    if (req_ibus && req_dbus) return ~last_gnt;
    return req_dbus ? M_DBUS : M_IBUS;
  endfunction

endpackage

// File: rtl/wb_sdram_arbiter_if.sv
// Bundle of both Wishbone master ports, the bridge-facing request/response and
// the timeout pulse. The arbiter takes the slave view, its environment the master view.
interface wb_sdram_arbiter_if;

  logic [31:0] m0_adr_i, m1_adr_i;
  logic [31:0] m0_dat_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i,  m1_we_i;
  logic        m0_cyc_i, m1_cyc_i;
  logic        m0_stb_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic        m0_err_o, m1_err_o;

  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o;
  logic        s_cyc_o;
  logic        s_stb_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic        timeout_o;

  modport slave (
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    input  m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i,
    output timeout_o
  );

  modport master (
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    output m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i,
    input  timeout_o
  );

endinterface

// File: rtl/wb_sdram_arbiter_watchdog.sv
// Saturating watchdog counter for a bridge transaction. clr restarts it, en lets
// it count; fire marks the cycle whose increment lands on the all-ones count.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fire
);

  localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Firing one cycle early in count terms lets the owner register the error on
  // the very edge where the count reaches CNT_MAX.
  assign fire = en && (cnt_q == CNT_MAX - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing the SDRAM bridge between the instruction and data
// Wishbone masters; one ack (or timeout err) is forwarded per transaction.
module wb_sdram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_sdram_arbiter_if.slave     bus
);

  arb_state_e  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_gnt_q, last_gnt_d;
  wb_req_t     s_req_q, s_req_d;
  logic        s_cyc_q, s_cyc_d;
  logic        s_stb_q, s_stb_d;
  logic [31:0] m0_dat_q, m0_dat_d;
  logic [31:0] m1_dat_q, m1_dat_d;
  logic        m0_ack_q, m0_ack_d;
  logic        m1_ack_q, m1_ack_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;
  logic        timeout_q, timeout_d;

  logic        req_ibus, req_dbus;
  logic        pick;
  wb_req_t     ibus_req, dbus_req;
  logic        wd_clr, wd_en, wd_fire;

  assign req_ibus = bus.m0_cyc_i && bus.m0_stb_i;
  assign req_dbus = bus.m1_cyc_i && bus.m1_stb_i;
  assign pick     = rr_pick(req_ibus, req_dbus, last_gnt_q);

  assign ibus_req = '{adr: bus.m0_adr_i, dat: bus.m0_dat_i, sel: bus.m0_sel_i, we: bus.m0_we_i};
  assign dbus_req = '{adr: bus.m1_adr_i, dat: bus.m1_dat_i, sel: bus.m1_sel_i, we: bus.m1_we_i};

  wb_arb_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .en   (wd_en),
    .fire (wd_fire)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch to hold it.
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    s_req_d    = s_req_q;
    s_cyc_d    = s_cyc_q;
    s_stb_d    = s_stb_q;
    m0_dat_d   = m0_dat_q;
    m1_dat_d   = m1_dat_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_err_d   = 1'b0;
    m1_err_d   = 1'b0;
    timeout_d  = 1'b0;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_ibus || req_dbus) begin
          state_d    = BUSY;
          gnt_d      = pick;
          last_gnt_d = pick;
          s_req_d    = (pick == M_DBUS) ? dbus_req : ibus_req;
          s_cyc_d    = 1'b1;
          s_stb_d    = 1'b1;
          wd_clr     = 1'b1;
        end
      end

      // The request stays frozen here even if the master aborts: the bridge
      // has no way to cancel, so only its ack or the watchdog ends the cycle.
      BUSY: begin
        wd_en = 1'b1;
        if (bus.s_ack_i) begin
          state_d = RELEASE;
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          if (gnt_q == M_DBUS) begin
            m1_dat_d = bus.s_dat_i;
            m1_ack_d = 1'b1;
          end else begin
            m0_dat_d = bus.s_dat_i;
            m0_ack_d = 1'b1;
          end
        end else if (wd_fire) begin
          state_d   = RELEASE;
          s_cyc_d   = 1'b0;
          s_stb_d   = 1'b0;
          timeout_d = 1'b1;
          m1_err_d  = (gnt_q == M_DBUS);
          m0_err_d  = (gnt_q == M_IBUS);
        end
      end

      // A stretched bridge ack is absorbed here until it drops.
      RELEASE: begin
        if (!bus.s_ack_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= M_IBUS;
      last_gnt_q <= M_DBUS;
      s_req_q    <= '0;
      s_cyc_q    <= 1'b0;
      s_stb_q    <= 1'b0;
      m0_dat_q   <= '0;
      m1_dat_q   <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values and the update order inside this block does not matter.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      s_req_q    <= s_req_d;
      s_cyc_q    <= s_cyc_d;
      s_stb_q    <= s_stb_d;
      m0_dat_q   <= m0_dat_d;
      m1_dat_q   <= m1_dat_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_err_q   <= m0_err_d;
      m1_err_q   <= m1_err_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.s_adr_o   = s_req_q.adr;
  assign bus.s_dat_o   = s_req_q.dat;
  assign bus.s_sel_o   = s_req_q.sel;
  assign bus.s_we_o    = s_req_q.we;
  assign bus.s_cyc_o   = s_cyc_q;
  assign bus.s_stb_o   = s_stb_q;
  assign bus.m0_dat_o  = m0_dat_q;
  assign bus.m1_dat_o  = m1_dat_q;
  assign bus.m0_ack_o  = m0_ack_q;
  assign bus.m1_ack_o  = m1_ack_q;
  assign bus.m0_err_o  = m0_err_q;
  assign bus.m1_err_o  = m1_err_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: a per-cycle vector table for basic and
// round-robin traffic, then hand sequences for held ack, timeout, abort and reset.
module tb_wb_sdram_arbiter;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  wb_sdram_arbiter_if bus ();

  wb_sdram_arbiter #(
    .TIMEOUT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        r0;
    logic        r1;
    logic        ack;
    logic [31:0] sdat;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_ack0;
    logic        e_ack1;
    logic [31:0] e_dat0;
    logic [31:0] e_dat1;
  } vec_t;

  vec_t vecs[15];

  function automatic logic [31:0] b(input logic x);
    return {31'b0, x};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic on);
    if (m == 0) begin
      bus.m0_cyc_i = on;
      bus.m0_stb_i = on;
    end else begin
      bus.m1_cyc_i = on;
      bus.m1_stb_i = on;
    end
  endtask

  // ack and err must never coincide, on one master or across both.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("resp_exclusive",
            b((bus.m0_ack_o & bus.m0_err_o) | (bus.m1_ack_o & bus.m1_err_o) |
              ((bus.m0_ack_o | bus.m0_err_o) & (bus.m1_ack_o | bus.m1_err_o))),
            32'd0);
    end
  end

  int acks0, acks1, err_at;

  initial begin
    //           name           rst   r0    r1    ack   sdat          cyc   adr       ack0  ack1  dat0          dat1
    vecs[0]  = '{"m0_grant",    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{"m0_wait1",    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2]  = '{"m0_wait2",    1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[3]  = '{"m0_ack",      1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[4]  = '{"m0_release",  1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h100, 1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{"reset",       1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        32'h0};
    vecs[6]  = '{"tie_m0",      1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[7]  = '{"tie_m0_ack",  1'b0, 1'b1, 1'b1, 1'b1, 32'h11110000, 1'b0, 32'h100, 1'b1, 1'b0, 32'h11110000, 32'h0};
    vecs[8]  = '{"tie_release", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h100, 1'b0, 1'b0, 32'h11110000, 32'h0};
    vecs[9]  = '{"rr_m1",       1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h200, 1'b0, 1'b0, 32'h11110000, 32'h0};
    vecs[10] = '{"rr_m1_ack",   1'b0, 1'b1, 1'b1, 1'b1, 32'h22220000, 1'b0, 32'h200, 1'b0, 1'b1, 32'h11110000, 32'h22220000};
    vecs[11] = '{"rr_release",  1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h200, 1'b0, 1'b0, 32'h11110000, 32'h22220000};
    vecs[12] = '{"rr_m0",       1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0, 1'b0, 32'h11110000, 32'h22220000};
    vecs[13] = '{"rr_m0_ack",   1'b0, 1'b1, 1'b0, 1'b1, 32'h33330000, 1'b0, 32'h100, 1'b1, 1'b0, 32'h33330000, 32'h22220000};
    vecs[14] = '{"idle",        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h100, 1'b0, 1'b0, 32'h33330000, 32'h22220000};

    rst = 1'b1;
    bus.m0_adr_i = 32'h100; bus.m0_dat_i = 32'h0; bus.m0_sel_i = 4'hF; bus.m0_we_i = 1'b0;
    bus.m1_adr_i = 32'h200; bus.m1_dat_i = 32'h0; bus.m1_sel_i = 4'hF; bus.m1_we_i = 1'b0;
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 32'h0;
    repeat (2) tick();

    check("rst_s_cyc",   b(bus.s_cyc_o), 32'd0);
    check("rst_s_stb",   b(bus.s_stb_o), 32'd0);
    check("rst_s_adr",   bus.s_adr_o, 32'd0);
    check("rst_s_dat",   bus.s_dat_o, 32'd0);
    check("rst_s_sel",   {28'b0, bus.s_sel_o}, 32'd0);
    check("rst_s_we",    b(bus.s_we_o), 32'd0);
    check("rst_m0_dat",  bus.m0_dat_o, 32'd0);
    check("rst_m1_dat",  bus.m1_dat_o, 32'd0);
    check("rst_acks",    {30'b0, bus.m0_ack_o, bus.m1_ack_o}, 32'd0);
    check("rst_errs",    {30'b0, bus.m0_err_o, bus.m1_err_o}, 32'd0);
    check("rst_timeout", b(bus.timeout_o), 32'd0);
    mon_en = 1'b1;

    for (int i = 0; i < 15; i++) begin
      rst         = vecs[i].rst;
      set_req(0, vecs[i].r0);
      set_req(1, vecs[i].r1);
      bus.s_ack_i = vecs[i].ack;
      bus.s_dat_i = vecs[i].sdat;
      tick();
      check({vecs[i].name, "_cyc"},  b(bus.s_cyc_o),  b(vecs[i].e_cyc));
      check({vecs[i].name, "_stb"},  b(bus.s_stb_o),  b(vecs[i].e_cyc));
      check({vecs[i].name, "_adr"},  bus.s_adr_o,     vecs[i].e_adr);
      check({vecs[i].name, "_ack0"}, b(bus.m0_ack_o), b(vecs[i].e_ack0));
      check({vecs[i].name, "_ack1"}, b(bus.m1_ack_o), b(vecs[i].e_ack1));
      check({vecs[i].name, "_dat0"}, bus.m0_dat_o,    vecs[i].e_dat0);
      check({vecs[i].name, "_dat1"}, bus.m1_dat_o,    vecs[i].e_dat1);
    end
    rst = 1'b0;

    // Held ack on an m1 write; m0 waits behind it.
    bus.m1_adr_i = 32'h300; bus.m1_dat_i = 32'h12345678; bus.m1_sel_i = 4'b0011; bus.m1_we_i = 1'b1;
    set_req(1, 1'b1);
    tick();
    check("wr_grant_cyc", b(bus.s_cyc_o), 32'd1);
    check("wr_grant_adr", bus.s_adr_o, 32'h300);
    check("wr_grant_dat", bus.s_dat_o, 32'h12345678);
    set_req(0, 1'b1);
    tick();
    check("wr_busy_sel", {28'b0, bus.s_sel_o}, 32'h3);
    check("wr_busy_we",  b(bus.s_we_o), 32'd1);
    check("wr_busy_cyc", b(bus.s_cyc_o), 32'd1);
    acks0 = 0;
    acks1 = 0;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hCAFE0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks0 += int'(bus.m0_ack_o);
      acks1 += int'(bus.m1_ack_o);
      check($sformatf("held_ack_no_cyc%0d", i), b(bus.s_cyc_o), 32'd0);
      if (bus.m1_ack_o) set_req(1, 1'b0);
    end
    bus.s_ack_i = 1'b0;
    tick();
    check("ack_fall_no_grant", b(bus.s_cyc_o), 32'd0);
    acks0 += int'(bus.m0_ack_o);
    acks1 += int'(bus.m1_ack_o);
    tick();
    check("next_grant_cyc", b(bus.s_cyc_o), 32'd1);
    check("next_grant_adr", bus.s_adr_o, 32'h100);
    check("held_m1_acks", acks1, 32'd1);
    check("held_m0_acks", acks0, 32'd0);
    check("held_m1_dat", bus.m1_dat_o, 32'hCAFE0000);
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h0BADF00D;
    tick();
    check("m0_after_held_ack", b(bus.m0_ack_o), 32'd1);
    check("m0_after_held_dat", bus.m0_dat_o, 32'h0BADF00D);
    set_req(0, 1'b0);
    bus.s_ack_i = 1'b0;
    tick();

    // Watchdog timeout on m0 (TIMEOUT_W=4): err 15 BUSY cycles after grant.
    bus.m0_adr_i = 32'h400;
    bus.m1_adr_i = 32'h200; bus.m1_dat_i = 32'h0; bus.m1_sel_i = 4'hF; bus.m1_we_i = 1'b0;
    set_req(0, 1'b1);
    tick();
    check("to_grant_adr", bus.s_adr_o, 32'h400);
    set_req(1, 1'b1);
    err_at = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.m0_err_o) begin
        err_at = k;
        break;
      end
      check($sformatf("to_busy_cyc%0d", k), b(bus.s_cyc_o), 32'd1);
    end
    check("to_err_cycle",   err_at, 32'd15);
    check("to_timeout_o",   b(bus.timeout_o), 32'd1);
    check("to_s_cyc_drop",  b(bus.s_cyc_o), 32'd0);
    check("to_m0_no_ack",   b(bus.m0_ack_o), 32'd0);
    check("to_m1_no_err",   b(bus.m1_err_o), 32'd0);
    check("to_dat_kept",    bus.m0_dat_o, 32'h0BADF00D);
    set_req(0, 1'b0);
    tick();
    check("to_err_one_cycle", {30'b0, bus.m0_err_o, bus.timeout_o}, 32'd0);
    tick();
    check("to_m1_grant_cyc", b(bus.s_cyc_o), 32'd1);
    check("to_m1_grant_adr", bus.s_adr_o, 32'h200);
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h77770000;
    tick();
    check("to_m1_ack", b(bus.m1_ack_o), 32'd1);
    check("to_m1_dat", bus.m1_dat_o, 32'h77770000);
    set_req(1, 1'b0);
    bus.s_ack_i = 1'b0;
    tick();

    // m1 aborts mid-BUSY; the request stays frozen and the ack still goes to m1.
    bus.m1_adr_i = 32'h500;
    set_req(1, 1'b1);
    tick();
    check("ab_grant_adr", bus.s_adr_o, 32'h500);
    set_req(1, 1'b0);
    bus.m1_adr_i = 32'hFFFF0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ab_hold_cyc%0d", i), b(bus.s_cyc_o), 32'd1);
      check($sformatf("ab_hold_stb%0d", i), b(bus.s_stb_o), 32'd1);
      check($sformatf("ab_hold_adr%0d", i), bus.s_adr_o, 32'h500);
    end
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h5555AAAA;
    tick();
    check("ab_m1_ack", b(bus.m1_ack_o), 32'd1);
    check("ab_m0_ack", b(bus.m0_ack_o), 32'd0);
    check("ab_m1_dat", bus.m1_dat_o, 32'h5555AAAA);
    check("ab_m0_dat", bus.m0_dat_o, 32'h0BADF00D);
    bus.s_ack_i = 1'b0;
    tick();

    // Asynchronous reset during BUSY, then a late ack from the bridge.
    set_req(0, 1'b1);
    tick();
    check("rb_grant_cyc", b(bus.s_cyc_o), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("rb_async_cyc", b(bus.s_cyc_o), 32'd0);
    check("rb_async_stb", b(bus.s_stb_o), 32'd0);
    set_req(0, 1'b0);
    tick();
    check("rb_m0_dat", bus.m0_dat_o, 32'd0);
    check("rb_m1_dat", bus.m1_dat_o, 32'd0);
    check("rb_s_adr",  bus.s_adr_o, 32'd0);
    rst = 1'b0;
    bus.s_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rb_late_ack%0d", i), {30'b0, bus.m0_ack_o, bus.m1_ack_o}, 32'd0);
      check($sformatf("rb_late_cyc%0d", i), b(bus.s_cyc_o), 32'd0);
    end
    bus.s_ack_i = 1'b0;
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    tick();
    check("rb_tie_m0_adr", bus.s_adr_o, 32'h400);
    bus.s_ack_i = 1'b1;
    tick();
    check("rb_tie_m0_ack", b(bus.m0_ack_o), 32'd1);
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    bus.s_ack_i = 1'b0;
    tick();
    tick();

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
